// File: rtl/board_render_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_render_ctrl
// Purpose  : Go-board render scheduler. Maps VGA pixels to the nearest 15x15
//            grid intersection, reads the stored stone colour for that cell,
//            and arbitrates the single board-storage port between render
//            reads, game-logic writes and full-board clear sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module board_render_ctrl #(
    parameter int SIDE_X_BEGIN = 102,
    parameter int SIDE_Y_BEGIN = 23,
    parameter int GRID_SIZE    = 31,
    parameter int HALF         = 15,
    parameter int N            = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       wr_req,
    input  logic [3:0] wr_row,
    input  logic [3:0] wr_col,
    input  logic [1:0] wr_color,
    output logic       wr_ack,
    input  logic       clr_req,
    output logic       busy,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic [1:0] cell_color,
    output logic       valid
);

    localparam int         c_cells = N * N;
    localparam int         c_x0    = SIDE_X_BEGIN - HALF;
    localparam int         c_y0    = SIDE_Y_BEGIN - HALF;
    localparam int         c_span  = N * GRID_SIZE;
    localparam logic [3:0] c_none  = 4'hF;

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_IDLE    = 2'd1,
        S_WR_WAIT = 2'd2
    } state_t;

    // Counts grid pitches passed along one axis: a comparator chain, no divide.
    function automatic logic [3:0] axis_cell(input logic [9:0] off);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int k = 1; k < N; k++) begin
            if (off >= 10'(k * GRID_SIZE)) cnt = cnt + 4'd1;
        end
        return cnt;
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_commit;
    logic [7:0] r_clr_cnt;
    logic       r_wr_ack;
    logic       r_s1_in;
    logic [3:0] r_s1_row;
    logic [3:0] r_s1_col;
    logic [1:0] r_mem [0:c_cells-1];

    // Range-checked offsets: pixels left of / above the window never wrap in.
    logic       w_x_in;
    logic       w_y_in;
    logic       w_in;
    logic [9:0] w_xo;
    logic [9:0] w_yo;
    logic [7:0] w_rd_addr;
    logic [7:0] w_wr_addr;
    logic       w_wr_in_range;
    logic       w_wr_valid;
    logic       w_rd_en;

    assign w_xo          = x - 10'(c_x0);
    assign w_yo          = y - 10'(c_y0);
    assign w_x_in        = (x >= 10'(c_x0)) && (w_xo < 10'(c_span));
    assign w_y_in        = (y >= 10'(c_y0)) && (w_yo < 10'(c_span));
    assign w_in          = w_x_in && w_y_in;
    assign w_rd_addr     = 8'({4'b0, r_s1_row} * 8'(N)) + {4'b0, r_s1_col};
    assign w_wr_addr     = 8'({4'b0, wr_row} * 8'(N)) + {4'b0, wr_col};
    assign w_wr_in_range = (wr_row < 4'(N)) && (wr_col < 4'(N));
    // The ack cycle still sees wr_req high; do not serve the same request twice.
    assign w_wr_valid    = wr_req && !r_wr_ack;
    assign w_rd_en       = r_s1_in && (r_state != S_CLEAR);
    assign busy          = (r_state == S_CLEAR);
    assign wr_ack        = r_wr_ack;

    // Stage 1: register the mapped cell and the in-window flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_in  <= 1'b0;
            r_s1_row <= c_none;
            r_s1_col <= c_none;
        end else begin
            r_s1_in  <= w_in;
            r_s1_row <= w_in ? axis_cell(w_yo) : c_none;
            r_s1_col <= w_in ? axis_cell(w_xo) : c_none;
        end
    end

    // Port-owner state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_CLEAR;
        else     r_state <= w_state_nxt;
    end

    // Next state and write commit: clear beats render read beats pending write.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt == 8'(c_cells - 1)) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_wr_valid) begin
                    if (!r_s1_in) w_commit    = 1'b1;
                    else          w_state_nxt = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                end else if (!r_s1_in) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Clear sweep address: held at zero outside CLEAR so every sweep starts at 0.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_CLEAR) r_clr_cnt <= 8'd0;
        else                           r_clr_cnt <= r_clr_cnt + 8'd1;
    end

    // Acknowledge pulse for the write committed on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) r_wr_ack <= 1'b0;
        else     r_wr_ack <= w_commit;
    end

    // Board storage write side: clear sweep or committed in-range write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR)               r_mem[r_clr_cnt] <= 2'b00;
            else if (w_commit && w_wr_in_range)   r_mem[w_wr_addr] <= wr_color;
        end
    end

    // Stage 2: storage read plus aligned row/col; blanked while clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= c_none;
            col        <= c_none;
            valid      <= 1'b0;
            cell_color <= 2'b00;
        end else begin
            row        <= r_s1_row;
            col        <= r_s1_col;
            valid      <= w_rd_en;
            cell_color <= w_rd_en ? r_mem[w_rd_addr] : 2'b00;
        end
    end

endmodule
`default_nettype wire
